// File: rtl/bid_round_sequencer.sv
// Host-side sequencer for the 3-player bid controller command port.
// Programs balances, mask, timer, bid cost and lock key, then runs a number
// of timed bid rounds, reports each round result and unlocks with the key.
// A controller error on any command aborts to FAULT. A cfg_valid seen in FAULT
// is accepted like one in IDLE and starts a new sequence straight away.
module bid_round_sequencer #(
    parameter int unsigned RLEN_W   = 8,
    parameter int unsigned OVER_TMO = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_x_init,
    input  logic [31:0]       cfg_y_init,
    input  logic [31:0]       cfg_z_init,
    input  logic [2:0]        cfg_mask,
    input  logic [3:0]        cfg_timer,
    input  logic [31:0]       cfg_bid_cost,
    input  logic [31:0]       cfg_key,
    input  logic [RLEN_W-1:0] cfg_round_len,
    input  logic [3:0]        cfg_rounds,
    output logic [3:0]        c_op,
    output logic [31:0]       c_data,
    output logic              c_start,
    input  logic              ctl_ready,
    input  logic [2:0]        ctl_err,
    input  logic              ctl_round_over,
    input  logic [2:0]        ctl_win,
    input  logic [31:0]       ctl_max_bid,
    output logic              res_valid,
    output logic [2:0]        res_win,
    output logic [31:0]       res_max_bid,
    output logic [3:0]        res_round,
    output logic              done,
    output logic              fault,
    output logic [2:0]        fault_code
);
    localparam int unsigned TMO_W = $clog2(OVER_TMO + 1);

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StLoad     = 4'd1;
    localparam logic [3:0] StLock     = 4'd2;
    localparam logic [3:0] StArm      = 4'd3;
    localparam logic [3:0] StRun      = 4'd4;
    localparam logic [3:0] StWaitOver = 4'd5;
    localparam logic [3:0] StReport   = 4'd6;
    localparam logic [3:0] StUnlock   = 4'd7;
    localparam logic [3:0] StDone     = 4'd8;
    localparam logic [3:0] StFault    = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [RLEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [3:0]        idx_q, idx_d;
    // Fault code to raise if ctl_err is nonzero this cycle; 0 means no command to check.
    logic [2:0]        chk_q, chk_d;

    logic [31:0]       x_q, y_q, z_q, cost_q, key_q;
    logic [2:0]        mask_q;
    logic [3:0]        timer_q;
    logic [RLEN_W-1:0] len_q;
    logic [3:0]        rounds_q;

    logic [3:0]  c_op_q, c_op_d;
    logic [31:0] c_data_q, c_data_d;
    logic        c_start_q, c_start_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        res_valid_q, res_valid_d;
    logic [2:0]  res_win_q, res_win_d;
    logic [31:0] res_max_bid_q, res_max_bid_d;
    logic [3:0]  res_round_q, res_round_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [2:0]  fault_code_q, fault_code_d;

    logic              accept;
    logic              err_hit;
    logic [RLEN_W-1:0] len_eff;
    logic [3:0]        rounds_eff;
    logic [2:0]        load_sel;
    logic [31:0]       load_word;

    assign accept     = cfg_valid && (((state_q == StIdle) && cfg_ready_q) || (state_q == StFault));
    assign err_hit    = (chk_q != 3'd0) && (ctl_err != 3'd0);
    assign len_eff    = (len_q == '0) ? RLEN_W'(1) : len_q;
    assign rounds_eff = (rounds_q == 4'd0) ? 4'd1 : rounds_q;
    assign load_sel   = step_q + 3'd1;

    // Operand for the next load command in the fixed LOAD order.
    always_comb begin
        unique case (load_sel)
            3'd1:    load_word = y_q;
            3'd2:    load_word = z_q;
            3'd3:    load_word = {29'b0, mask_q};
            3'd4:    load_word = {28'b0, timer_q};
            default: load_word = cost_q;
        endcase
    end

    // Next state and next (registered) output values.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        idx_d         = idx_q;
        chk_d         = 3'd0;
        c_op_d        = 4'd0;
        c_data_d      = 32'd0;
        c_start_d     = 1'b0;
        res_valid_d   = 1'b0;
        res_win_d     = res_win_q;
        res_max_bid_d = res_max_bid_q;
        res_round_d   = res_round_q;
        done_d        = 1'b0;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;

        unique case (state_q)
            StIdle, StFault: begin
                if (accept) begin
                    state_d      = StLoad;
                    step_d       = 3'd0;
                    idx_d        = 4'd0;
                    fault_d      = 1'b0;
                    fault_code_d = 3'd0;
                    c_op_d       = 4'd3;
                    c_data_d     = cfg_x_init;
                end
            end
            StLoad: begin
                if (err_hit) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = chk_q;
                end else begin
                    chk_d = 3'd1;
                    if (step_q == 3'd5) begin
                        state_d  = StLock;
                        c_op_d   = 4'd2;
                        c_data_d = key_q;
                    end else begin
                        step_d   = load_sel;
                        c_op_d   = {1'b0, load_sel} + 4'd3;
                        c_data_d = load_word;
                    end
                end
            end
            StLock: begin
                // The error for the last load op arrives while the lock op is out.
                if (err_hit) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = chk_q;
                end else begin
                    chk_d   = 3'd2;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (err_hit) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = chk_q;
                end else if (ctl_ready) begin
                    state_d   = StRun;
                    cnt_d     = RLEN_W'(1);
                    c_start_d = 1'b1;
                end
            end
            StRun: begin
                if (cnt_q == len_eff) begin
                    state_d = StWaitOver;
                    tmo_d   = TMO_W'(1);
                end else begin
                    cnt_d     = cnt_q + RLEN_W'(1);
                    c_start_d = 1'b1;
                end
            end
            StWaitOver: begin
                if (ctl_round_over) begin
                    state_d       = StReport;
                    res_valid_d   = 1'b1;
                    res_win_d     = ctl_win;
                    res_max_bid_d = ctl_max_bid;
                    res_round_d   = idx_q;
                end else if (tmo_q == TMO_W'(OVER_TMO)) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = 3'd3;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StReport: begin
                if (({1'b0, idx_q} + 5'd1) < {1'b0, rounds_eff}) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StArm;
                end else begin
                    state_d  = StUnlock;
                    step_d   = 3'd0;
                    c_op_d   = 4'd1;
                    c_data_d = key_q;
                end
            end
            StUnlock: begin
                // Step 0 has the unlock op on the bus; step 1 checks its error.
                if (step_q == 3'd0) begin
                    chk_d  = 3'd4;
                    step_d = 3'd1;
                end else if (err_hit) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = chk_q;
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cfg_ready_d = (state_d == StIdle);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            step_q        <= 3'd0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            idx_q         <= 4'd0;
            chk_q         <= 3'd0;
            c_op_q        <= 4'd0;
            c_data_q      <= 32'd0;
            c_start_q     <= 1'b0;
            cfg_ready_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_win_q     <= 3'd0;
            res_max_bid_q <= 32'd0;
            res_round_q   <= 4'd0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 3'd0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            c_op_q        <= c_op_d;
            c_data_q      <= c_data_d;
            c_start_q     <= c_start_d;
            cfg_ready_q   <= cfg_ready_d;
            res_valid_q   <= res_valid_d;
            res_win_q     <= res_win_d;
            res_max_bid_q <= res_max_bid_d;
            res_round_q   <= res_round_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    // Configuration captured only on accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            z_q      <= 32'd0;
            mask_q   <= 3'd0;
            timer_q  <= 4'd0;
            cost_q   <= 32'd0;
            key_q    <= 32'd0;
            len_q    <= '0;
            rounds_q <= 4'd0;
        end else if (accept) begin
            x_q      <= cfg_x_init;
            y_q      <= cfg_y_init;
            z_q      <= cfg_z_init;
            mask_q   <= cfg_mask;
            timer_q  <= cfg_timer;
            cost_q   <= cfg_bid_cost;
            key_q    <= cfg_key;
            len_q    <= cfg_round_len;
            rounds_q <= cfg_rounds;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign c_op        = c_op_q;
    assign c_data      = c_data_q;
    assign c_start     = c_start_q;
    assign res_valid   = res_valid_q;
    assign res_win     = res_win_q;
    assign res_max_bid = res_max_bid_q;
    assign res_round   = res_round_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
endmodule

// File: tb/tb_bid_round_sequencer.sv
// Self-checking bench for bid_round_sequencer: a small controller model answers
// rounds with random results, and expected command traces come from the config.
module tb_bid_round_sequencer;
    localparam int RLEN_W   = 8;
    localparam int OVER_TMO = 16;
    localparam int MAXC     = 3000;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [2:0]  mask;
        logic [3:0]  timer;
        logic [31:0] cost;
        logic [31:0] key;
        logic [7:0]  len;
        logic [3:0]  rounds;
    } cfg_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [31:0]       cfg_x_init, cfg_y_init, cfg_z_init, cfg_bid_cost, cfg_key;
    logic [2:0]        cfg_mask;
    logic [3:0]        cfg_timer, cfg_rounds;
    logic [RLEN_W-1:0] cfg_round_len;
    logic [3:0]        c_op;
    logic [31:0]       c_data;
    logic              c_start;
    logic              ctl_ready;
    logic [2:0]        ctl_err;
    logic              ctl_round_over;
    logic [2:0]        ctl_win;
    logic [31:0]       ctl_max_bid;
    logic              res_valid;
    logic [2:0]        res_win;
    logic [31:0]       res_max_bid;
    logic [3:0]        res_round;
    logic              done;
    logic              fault;
    logic [2:0]        fault_code;

    int checks = 0;
    int failures = 0;

    // Observations of one run and the model's expectations.
    logic [35:0] obs_ops[$];
    int          obs_op_cyc[$];
    int          obs_starts[$];
    logic [38:0] obs_res[$];
    logic [38:0] exp_res[$];
    logic [35:0] exp_ops[$];
    int          exp_len, exp_rounds;
    int          done_cnt, overlap_cnt, fell_at, fault_at;
    logic        last_fault;
    logic [2:0]  last_code;
    bit          timed_out;

    always #5 clk = ~clk;

    bid_round_sequencer #(.RLEN_W(RLEN_W), .OVER_TMO(OVER_TMO)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_x_init(cfg_x_init), .cfg_y_init(cfg_y_init), .cfg_z_init(cfg_z_init),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_bid_cost(cfg_bid_cost),
        .cfg_key(cfg_key), .cfg_round_len(cfg_round_len), .cfg_rounds(cfg_rounds),
        .c_op(c_op), .c_data(c_data), .c_start(c_start), .ctl_ready(ctl_ready),
        .ctl_err(ctl_err), .ctl_round_over(ctl_round_over), .ctl_win(ctl_win),
        .ctl_max_bid(ctl_max_bid), .res_valid(res_valid), .res_win(res_win),
        .res_max_bid(res_max_bid), .res_round(res_round), .done(done), .fault(fault),
        .fault_code(fault_code)
    );

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.x = $urandom; c.y = $urandom; c.z = $urandom; c.mask = 3'($urandom);
        c.timer = 4'($urandom); c.cost = $urandom; c.key = $urandom;
        c.len = 8'($urandom_range(0, 6)); c.rounds = 4'($urandom_range(0, 4));
        return c;
    endfunction

    // Expected command trace: six loads, lock, then unlock, all with the latched values.
    task automatic build_model(input cfg_t c);
        exp_ops.delete();
        exp_ops.push_back({4'd3, c.x});
        exp_ops.push_back({4'd4, c.y});
        exp_ops.push_back({4'd5, c.z});
        exp_ops.push_back({4'd6, 29'd0, c.mask});
        exp_ops.push_back({4'd7, 28'd0, c.timer});
        exp_ops.push_back({4'd8, c.cost});
        exp_ops.push_back({4'd2, c.key});
        exp_ops.push_back({4'd1, c.key});
        exp_len    = (c.len == 0) ? 1 : int'(c.len);
        exp_rounds = (c.rounds == 0) ? 1 : int'(c.rounds);
    endtask

    task automatic drive_cfg(input cfg_t c);
        cfg_x_init = c.x; cfg_y_init = c.y; cfg_z_init = c.z; cfg_mask = c.mask;
        cfg_timer = c.timer; cfg_bid_cost = c.cost; cfg_key = c.key;
        cfg_round_len = c.len; cfg_rounds = c.rounds;
    endtask

    // Presents one request; returns at the first sample after the accepting edge.
    task automatic accept_cfg(input cfg_t c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cfg_ready || fault) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            drive_cfg(c);
            cfg_valid = 1'b1;
            @(posedge clk); #1;
            cfg_valid = 1'b0;
        end
    endtask

    // Runs one sequence with the controller model, recording what the DUT does.
    task automatic run_cfg(input cfg_t c, input bit noise, input bit unlock_err, input bit hold_over);
        int burst, delay, tail;
        bit err_next, ok;
        obs_ops.delete(); obs_op_cyc.delete(); obs_starts.delete(); obs_res.delete();
        exp_res.delete();
        done_cnt = 0; overlap_cnt = 0; fell_at = -1; fault_at = -1; timed_out = 1'b1;
        build_model(c);
        accept_cfg(c, ok);
        if (!ok) return;
        burst = 0; delay = -1; tail = -1; err_next = 1'b0;
        for (int cyc = 0; cyc < MAXC; cyc++) begin
            if (c_op != 4'd0) begin
                obs_ops.push_back({c_op, c_data});
                obs_op_cyc.push_back(cyc);
            end
            if (c_start && c_op != 4'd0) overlap_cnt++;
            if (c_start) burst++;
            else if (burst != 0) begin
                obs_starts.push_back(burst);
                burst = 0;
                fell_at = cyc;
                delay = hold_over ? -1 : int'($urandom_range(0, 4));
            end
            if (res_valid) obs_res.push_back({res_win, res_max_bid, res_round});
            if (done) done_cnt++;
            if (fault && fault_at < 0) fault_at = cyc;
            last_fault = fault;
            last_code = fault_code;
            if ((done || fault) && tail < 0) tail = 3;
            ctl_round_over = 1'b0;
            if (delay == 0) begin
                ctl_round_over = 1'b1;
                ctl_win = 3'($urandom);
                ctl_max_bid = $urandom;
                exp_res.push_back({ctl_win, ctl_max_bid, 4'(exp_res.size())});
                delay = -1;
            end else if (delay > 0) delay--;
            // Player-level errors during a round must not disturb the sequencer.
            ctl_err = err_next ? 3'b001 : (c_start ? 3'($urandom) : 3'd0);
            err_next = unlock_err && (c_op == 4'd1);
            ctl_ready = ($urandom_range(0, 3) != 0);
            if (noise && tail < 0) begin
                cfg_valid = 1'b1;
                drive_cfg(rand_cfg());
            end else cfg_valid = 1'b0;
            if (tail == 0) begin
                timed_out = 1'b0;
                break;
            end
            if (tail > 0) tail--;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0; ctl_round_over = 1'b0; ctl_err = 3'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({c_op, c_data, c_start} !== 37'd0) begin failures++;
            $display("FAIL reset_cmd got=%0h exp=0", {c_op, c_data, c_start}); end
        checks++; if (cfg_ready !== 1'b0) begin failures++;
            $display("FAIL reset_ready got=%0b exp=0", cfg_ready); end
        checks++; if ({res_valid, res_win, res_max_bid, res_round} !== 40'd0) begin failures++;
            $display("FAIL reset_res got=%0h exp=0", {res_valid, res_win, res_max_bid, res_round}); end
        checks++; if ({done, fault, fault_code} !== 5'd0) begin failures++;
            $display("FAIL reset_status got=%0h exp=0", {done, fault, fault_code}); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (cfg_ready !== 1'b1) begin failures++;
            $display("FAIL reset_ready_after got=%0b exp=1", cfg_ready); end
    endtask

    task automatic test_basic();
        cfg_t c;
        c = '{x: 100, y: 200, z: 300, mask: 3'd7, timer: 4'd2, cost: 1, key: 32'hA5, len: 3, rounds: 1};
        run_cfg(c, 1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (obs_ops.size() != exp_ops.size()) begin failures++;
            $display("FAIL basic_op_count got=%0d exp=%0d", obs_ops.size(), exp_ops.size()); end
        for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++) begin
            checks++; if (obs_ops[i] !== exp_ops[i]) begin failures++;
                $display("FAIL basic_op[%0d] got=%0h exp=%0h", i, obs_ops[i], exp_ops[i]); end
        end
        for (int i = 0; i < 7 && i < obs_op_cyc.size(); i++) begin
            checks++; if (obs_op_cyc[i] != i) begin failures++;
                $display("FAIL basic_op_cycle[%0d] got=%0d exp=%0d", i, obs_op_cyc[i], i); end
        end
        checks++; if (obs_starts.size() != 1 || obs_starts[0] != 3) begin failures++;
            $display("FAIL basic_start got=%0d bursts exp=1 burst of 3", obs_starts.size()); end
        checks++; if (obs_res.size() != 1 || exp_res.size() != 1 || obs_res[0] !== exp_res[0]) begin
            failures++; $display("FAIL basic_result got=%0d results exp=1 matching", obs_res.size()); end
        checks++; if (done_cnt != 1 || last_fault !== 1'b0) begin failures++;
            $display("FAIL basic_done got=%0d/%0b exp=1/0", done_cnt, last_fault); end
    endtask

    task automatic test_multi_round();
        cfg_t c;
        int unlocks;
        c = rand_cfg(); c.len = 2; c.rounds = 3;
        run_cfg(c, 1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL multi_timeout got=1 exp=0"); end
        checks++; if (obs_starts.size() != 3) begin failures++;
            $display("FAIL multi_bursts got=%0d exp=3", obs_starts.size()); end
        foreach (obs_starts[i]) begin
            checks++; if (obs_starts[i] != 2) begin failures++;
                $display("FAIL multi_burst_len[%0d] got=%0d exp=2", i, obs_starts[i]); end
        end
        checks++; if (obs_res.size() != 3 || exp_res.size() != 3) begin failures++;
            $display("FAIL multi_res_count got=%0d exp=3", obs_res.size()); end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            checks++; if (obs_res[i] !== exp_res[i]) begin failures++;
                $display("FAIL multi_res[%0d] got=%0h exp=%0h", i, obs_res[i], exp_res[i]); end
        end
        unlocks = 0;
        foreach (obs_ops[i]) if (obs_ops[i][35:32] == 4'd1) unlocks++;
        checks++; if (unlocks != 1 || done_cnt != 1) begin failures++;
            $display("FAIL multi_unlock got=%0d unlocks %0d done exp=1 1", unlocks, done_cnt); end
    endtask

    task automatic test_unlock_err();
        cfg_t c;
        c = rand_cfg(); c.rounds = 2;
        run_cfg(c, 1'b0, 1'b1, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL unlock_err_timeout got=1 exp=0"); end
        checks++; if (last_fault !== 1'b1 || last_code !== 3'd4) begin failures++;
            $display("FAIL unlock_err_code got=%0b/%0d exp=1/4", last_fault, last_code); end
        checks++; if (done_cnt != 0) begin failures++;
            $display("FAIL unlock_err_done got=%0d exp=0", done_cnt); end
        checks++; if (obs_res.size() != 2) begin failures++;
            $display("FAIL unlock_err_res got=%0d exp=2", obs_res.size()); end
    endtask

    // Starts from FAULT, so it also covers accepting a request there.
    task automatic test_zero_len();
        cfg_t c;
        c = rand_cfg(); c.len = 0; c.rounds = 0;
        run_cfg(c, 1'b1, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL zero_timeout got=1 exp=0"); end
        checks++; if (obs_ops.size() < 1 || obs_ops[0] !== exp_ops[0]) begin failures++;
            $display("FAIL zero_first_op got=%0d ops exp=first %0h", obs_ops.size(), exp_ops[0]); end
        checks++; if (obs_starts.size() != 1 || obs_starts[0] != 1) begin failures++;
            $display("FAIL zero_start got=%0d bursts exp=1 burst of 1", obs_starts.size()); end
        checks++; if (obs_res.size() != 1 || done_cnt != 1 || last_fault !== 1'b0) begin failures++;
            $display("FAIL zero_finish got=%0d res %0d done exp=1 1", obs_res.size(), done_cnt); end
    endtask

    task automatic test_timeout();
        cfg_t c;
        c = rand_cfg(); c.rounds = 2;
        run_cfg(c, 1'b0, 1'b0, 1'b1);
        checks++; if (timed_out) begin failures++; $display("FAIL tmo_timeout got=1 exp=0"); end
        checks++; if (last_fault !== 1'b1 || last_code !== 3'd3) begin failures++;
            $display("FAIL tmo_code got=%0b/%0d exp=1/3", last_fault, last_code); end
        checks++; if (fault_at - fell_at != OVER_TMO) begin failures++;
            $display("FAIL tmo_delay got=%0d exp=%0d", fault_at - fell_at, OVER_TMO); end
        checks++; if (done_cnt != 0 || obs_res.size() != 0) begin failures++;
            $display("FAIL tmo_side got=%0d done %0d res exp=0 0", done_cnt, obs_res.size()); end
    endtask

    task automatic test_random();
        cfg_t c;
        for (int n = 0; n < 6; n++) begin
            c = rand_cfg();
            run_cfg(c, 1'b1, 1'b0, 1'b0);
            checks++; if (timed_out) begin failures++; $display("FAIL rnd%0d_timeout got=1 exp=0", n); end
            checks++; if (obs_ops.size() != exp_ops.size()) begin failures++;
                $display("FAIL rnd%0d_op_count got=%0d exp=%0d", n, obs_ops.size(), exp_ops.size()); end
            for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++) begin
                checks++; if (obs_ops[i] !== exp_ops[i]) begin failures++;
                    $display("FAIL rnd%0d_op[%0d] got=%0h exp=%0h", n, i, obs_ops[i], exp_ops[i]); end
            end
            checks++; if (obs_starts.size() != exp_rounds) begin failures++;
                $display("FAIL rnd%0d_bursts got=%0d exp=%0d", n, obs_starts.size(), exp_rounds); end
            foreach (obs_starts[i]) begin
                checks++; if (obs_starts[i] != exp_len) begin failures++;
                    $display("FAIL rnd%0d_burst[%0d] got=%0d exp=%0d", n, i, obs_starts[i], exp_len); end
            end
            checks++; if (obs_res.size() != exp_res.size()) begin failures++;
                $display("FAIL rnd%0d_res_count got=%0d exp=%0d", n, obs_res.size(), exp_res.size()); end
            for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
                checks++; if (obs_res[i] !== exp_res[i]) begin failures++;
                    $display("FAIL rnd%0d_res[%0d] got=%0h exp=%0h", n, i, obs_res[i], exp_res[i]); end
            end
            checks++; if (done_cnt != 1 || last_fault !== 1'b0 || overlap_cnt != 0) begin failures++;
                $display("FAIL rnd%0d_end got=done %0d fault %0b overlap %0d exp=1 0 0",
                         n, done_cnt, last_fault, overlap_cnt); end
        end
    endtask

    task automatic test_reset_mid_run();
        cfg_t c;
        bit ok, seen;
        c = rand_cfg(); c.len = 20; c.rounds = 2;
        ctl_ready = 1'b1;
        accept_cfg(c, ok);
        seen = 1'b0;
        for (int i = 0; i < 60 && ok; i++) begin
            if (c_start) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL midrst_start got=0 exp=1"); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (c_start !== 1'b0 || c_op !== 4'd0 || cfg_ready !== 1'b0) begin failures++;
            $display("FAIL midrst_drop got=%0b/%0d/%0b exp=0/0/0", c_start, c_op, cfg_ready); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (cfg_ready !== 1'b1 || c_start !== 1'b0) begin failures++;
            $display("FAIL midrst_ready got=%0b/%0b exp=1/0", cfg_ready, c_start); end
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; ctl_ready = 1'b1; ctl_err = 3'd0;
        ctl_round_over = 1'b0; ctl_win = 3'd0; ctl_max_bid = 32'd0;
        drive_cfg('0);
        test_reset();
        test_basic();
        test_multi_round();
        test_unlock_err();
        test_zero_len();
        test_timeout();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
